rr_octal_arbiter: RTL
=====================

# rr_octal_arbiter

Round-robin arbiter that shares a single downstream resource among eight requesters. Grants are one-hot and held until the grantee releases, drops its request, or times out. The one-hot grant is converted to a 3-bit index by the team's existing octal_binary encoder. The index drives the select/address of the shared datapath.

## Interface

Parameters:
- HOLD_MAX, default 15: maximum cycles a grant may be held. 0 disables the timeout.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 8: request vector; bit i = requester i.
- done, input, 1: current grantee releases the resource; ignored when no grant is active.
- gnt, output, 8: one-hot grant vector, or all zeros.
- gnt_bin, output, 3: binary index of the granted requester, from octal_binary; 0 when idle.
- gnt_valid, output, 1: high while a grant is active; equal to |gnt.
- timeout, output, 1: single-cycle pulse on a forced release.

## Operation

- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first set bit of req searching upward from ptr, wrapping 7→0.
  - Register gnt to that one-hot value, clear hold_cnt, and go to GRANT.
  - If req == 0, stay in IDLE with all outputs 0.
- GRANT: release when any of the following is true in the current cycle:
  - done is high;
  - req[gnt index] is low;
  - HOLD_MAX != 0 and hold_cnt == HOLD_MAX-1.
- On release:
  - gnt is cleared;
  - ptr becomes (grantee index + 1) mod 8;
  - the FSM returns to IDLE.
- Otherwise hold_cnt increments.
- timeout pulses only when the release cause is the counter alone. If done or a dropped request coincides with the counter limit, timeout stays 0.
- ptr is 3 bits and wraps naturally.
- hold_cnt width is $clog2(HOLD_MAX+1), minimum 1 bit.
- Requests from non-granted requesters during GRANT do not affect the current grant.
- Requester changes during IDLE are sampled only on the arbitration cycle.
- Reset:
  - FSM goes to IDLE; ptr=0; hold_cnt=0.
  - gnt=0, gnt_bin=0, gnt_valid=0, timeout=0.
  - Reset in the middle of a grant aborts the grant immediately and does not pulse timeout.

## Timing

- Arbitration latency: req seen in IDLE at edge N gives gnt, gnt_bin and gnt_valid valid after edge N (one cycle).
- Release latency: a release condition sampled at edge M gives gnt=0 after edge M. timeout is high in the same cycle in which gnt falls to 0.
- One mandatory IDLE cycle separates consecutive grants. Sustained throughput is therefore one grant per 2 + hold cycles.
- With HOLD_MAX=H, a grant is visible for at most H cycles.
- gnt_bin is combinational from the registered gnt through octal_binary, so it has no extra latency. It must never show an index that differs from gnt.
- done is a level sampled each GRANT cycle. A done held across IDLE has no effect on the next arbitration, but it releases the next grant on that grant's first cycle.

## Structure

- Shared package:
  - NUM_REQ=8, IDX_W=3;
  - FSM state encoding (IDLE=1'b0, GRANT=1'b1);
  - function rr_pick(req, ptr) returning the one-hot selection.
- Sub-module: instantiate the existing octal_binary (input oct[7:0], output bin[2:0]) for the gnt → gnt_bin conversion. Do not re-implement the encoder.
- Top holds the FSM, ptr, hold_cnt and the gnt register.

## Test plan

1. Reset: rst high 2 cycles with req=8'hFF → gnt=0, gnt_bin=0, gnt_valid=0, timeout=0. First grant after rst falls is requester 0.
2. Single request:
   - req=8'b0000_0100 → next cycle gnt=8'b0000_0100, gnt_bin=3'd2.
   - 3 cycles later, pulse done → gnt=0 the following cycle.
   - New req=8'b0000_1100 → grant goes to 3, since ptr=3.
3. Fairness/wrap: req=8'hFF held, done pulsed on each grant's first cycle → gnt_bin sequence 0,1,2,…,7,0,1 with one idle cycle between grants.
4. Timeout:
   - HOLD_MAX=4, req=8'b0010_0000 held, done=0 → gnt_bin=5 for exactly 4 cycles, timeout high 1 cycle as gnt drops.
   - Re-grant to 5 after one idle cycle.
5. Coincident release: HOLD_MAX=4, done asserted on the 4th grant cycle → gnt released, timeout stays 0, ptr advances.
6. Reset mid-grant: grant to requester 6, assert rst on its 2nd cycle → all outputs 0 next cycle, ptr=0. With req=8'b0100_0001 after reset, the grant goes to 0.

Source files
------------

// File: rtl/rr_octal_arbiter_pkg.sv
// rtl/rr_octal_arbiter_pkg.sv - shared constants, FSM encoding and round-robin pick function
package rr_octal_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot of the first set request at or above ptr, wrapping 7 -> 0.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [NUM_REQ-1:0] pick;
        logic               found;
        logic [IDX_W-1:0]   idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/octal_binary.sv
// rtl/octal_binary.sv - one-hot (8 bit) to 3-bit binary index encoder; zero input gives 0
module octal_binary (
    input  logic [7:0] oct,
    output logic [2:0] bin
);

    assign bin[0] = oct[1] | oct[3] | oct[5] | oct[7];
    assign bin[1] = oct[2] | oct[3] | oct[6] | oct[7];
    assign bin[2] = oct[4] | oct[5] | oct[6] | oct[7];

endmodule

// File: rtl/rr_octal_arbiter.sv
// rtl/rr_octal_arbiter.sv - eight-way round-robin arbiter with held grants and optional hold timeout
module rr_octal_arbiter
    import rr_octal_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [IDX_W-1:0]     gnt_bin,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int                CNT_W     = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam bit                TIMER_EN  = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    state_t               r_state;
    logic [IDX_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_hold_cnt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_timeout;

    state_t               w_state_next;
    logic [IDX_W-1:0]     w_ptr_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [NUM_REQ-1:0]   w_gnt_next;
    logic                 w_timeout_next;
    logic [IDX_W-1:0]     w_gnt_bin;
    logic                 w_rel_user;
    logic                 w_rel_timer;

    octal_binary u_octal_binary (
        .oct (r_gnt),
        .bin (w_gnt_bin)
    );

    // A user release (done or dropped request) masks the timeout pulse.
    assign w_rel_user  = done | ~(|(req & r_gnt));
    assign w_rel_timer = TIMER_EN && (r_hold_cnt == HOLD_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_cnt_next     = r_hold_cnt;
        w_gnt_next     = r_gnt;
        w_timeout_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_gnt_next   = rr_pick(req, r_ptr);
                    w_cnt_next   = '0;
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_rel_user || w_rel_timer) begin
                    w_gnt_next     = '0;
                    w_cnt_next     = '0;
                    w_ptr_next     = w_gnt_bin + IDX_W'(1);
                    w_timeout_next = w_rel_timer & ~w_rel_user;
                    w_state_next   = ST_IDLE;
                end else begin
                    w_cnt_next = r_hold_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= w_cnt_next;
            r_gnt      <= w_gnt_next;
            r_timeout  <= w_timeout_next;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_bin   = w_gnt_bin;
    assign gnt_valid = |r_gnt;
    assign timeout   = r_timeout;

endmodule
